// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32i memory constants and dumper state encoding
package rv32_pkg;

    localparam int RV_ADDR_W = 10;
    localparam int RV_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } dump_state_t;

endpackage

// File: rtl/data_mem_dumper_fifo.sv
// rtl/data_mem_dumper_fifo.sv - output buffer for dumped words (data, address, last flag)
module dump_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/data_mem_dumper.sv
// rtl/data_mem_dumper.sv - streams a contiguous data-memory range out on a valid/ready port
module data_mem_dumper
    import rv32_pkg::*;
#(
    parameter int ADDR_W     = RV_ADDR_W,
    parameter int DATA_W     = RV_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);
    localparam int FW = DATA_W + ADDR_W + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_OCC = OW'(FIFO_DEPTH);

    dump_state_t       state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   remaining;
    logic [1:0]        inflight;
    logic              rd_pending;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_last;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FW-1:0]     head;
    logic              pop;
    logic              push;
    logic              issue;
    logic              clear;
    logic [OW-1:0]     occupancy;

    assign pop       = out_valid && out_ready;
    assign clear     = abort && (state != ST_IDLE);
    // Words buffered plus words still coming back, net of the beat leaving now.
    assign occupancy = OW'(fifo_count) + OW'(inflight) - OW'(pop);
    assign issue     = (state == ST_RUN) && (remaining != '0) && !abort
                       && (occupancy < DEPTH_OCC);
    assign push      = rd_pending && (!fifo_full || pop);

    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_ptr;
    assign out_valid   = !fifo_empty;
    assign {out_data, out_addr, out_last} = head;

    dump_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data ({mem_rd_data, pend_addr, pend_last}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            remaining  <= '0;
            inflight   <= '0;
            rd_pending <= 1'b0;
            pend_addr  <= '0;
            pend_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            rd_pending <= issue;
            pend_addr  <= rd_ptr;
            pend_last  <= (remaining == (ADDR_W+1)'(1));
            if (issue) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
            // A read returning after abort is dropped, so its count goes too.
            if (clear) begin
                inflight <= '0;
            end else begin
                inflight <= inflight + 2'(issue) - 2'(rd_pending);
            end
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        rd_ptr    <= base_addr;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        state     <= (word_count == '0) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (remaining == '0 && inflight == '0) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (fifo_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_dumper.sv
// tb/tb_data_mem_dumper.sv - directed self-checking bench for data_mem_dumper
module tb_data_mem_dumper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_count = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [9:0]  out_addr;
    logic        out_last;

    logic [31:0] mem_img [1024];

    int          checks = 0;
    int          errors = 0;

    logic [42:0] beat_q [$];
    int          beat_cyc [$];
    int          done_cyc;
    logic        done_busy;
    logic        busy1;
    int          rd_en_seen;
    int          valid_seen;
    int          max_out;

    data_mem_dumper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_img[mem_rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        case (mode)
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       return cyc >= 12;
            default: return 1'b1;
        endcase
    endfunction

    // Start accepted in cycle 0; each loop pass samples one cycle 2ns after its edge.
    task automatic run_dump(input logic [9:0] base, input logic [10:0] cnt,
                            input int mode, input int restart_cyc);
        int          issued;
        int          popped;
        logic        pv;
        logic        pr;
        logic [42:0] pw;
        issued = 0; popped = 0; pv = 1'b0; pr = 1'b0; pw = '0;
        beat_q.delete(); beat_cyc.delete();
        done_cyc = -1; done_busy = 1'b1; valid_seen = 0; max_out = 0;
        base_addr = base; word_count = cnt; start = 1'b1; out_ready = rdy(mode, 0);
        tick();
        start = 1'b0;
        busy1 = busy;
        for (int cyc = 1; cyc < 60 && done_cyc < 0; cyc++) begin
            start = (cyc == restart_cyc);
            if (start) begin
                base_addr  = 10'h155;
                word_count = 11'd3;
            end
            out_ready = rdy(mode, cyc);
            #1;
            if (pv && !pr)
                check("hold_stable", {out_valid, out_data, out_addr, out_last}, {1'b1, pw});
            if (mem_rd_en) issued++;
            if (out_valid) valid_seen++;
            if (out_valid && out_ready) begin
                beat_q.push_back({out_data, out_addr, out_last});
                beat_cyc.push_back(cyc);
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (done) begin
                done_cyc  = cyc;
                done_busy = busy;
            end
            pv = out_valid; pr = out_ready; pw = {out_data, out_addr, out_last};
            tick();
        end
        start = 1'b0;
        rd_en_seen = issued;
        check("done_single_cycle", done, 1'b0);
    endtask

    task automatic verify_dump(input string name, input logic [9:0] base,
                               input int cnt, input int mode);
        logic [9:0]  a;
        logic [42:0] exp;
        check({name, "_busy_c1"}, busy1, 1'b1);
        check({name, "_beats"}, beat_q.size(), cnt);
        check({name, "_reads"}, rd_en_seen, cnt);
        check({name, "_done_seen"}, done_cyc >= 0, 1'b1);
        check({name, "_busy_at_done"}, done_busy, 1'b0);
        check({name, "_max_outstanding"}, max_out <= 4, 1'b1);
        if (cnt == 0) begin
            check({name, "_done_cyc"}, done_cyc, 2);
            check({name, "_no_valid"}, valid_seen, 0);
        end
        for (int i = 0; i < beat_q.size() && i < cnt; i++) begin
            a   = base + 10'(i);
            exp = {mem_img[a], a, (i == cnt - 1)};
            check({name, "_beat"}, beat_q[i], exp);
            if (mode == 0) check({name, "_beat_cyc"}, beat_cyc[i], 3 + i);
        end
        if (beat_q.size() > 0)
            check({name, "_done_after_last"}, done_cyc, beat_cyc[beat_q.size()-1] + 2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_img[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem_img[i] = 32'hA0 + i;
        mem_img[10'h3FE] = 32'hB0;
        mem_img[10'h3FF] = 32'hB1;
        for (int i = 0; i < 8; i++) mem_img[10'h10 + i] = 32'hC0 + i;
        mem_img[10'h20] = 32'hD0;
        mem_img[10'h21] = 32'hD1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_rd_addr", mem_rd_addr, 10'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_out", {out_data, out_addr, out_last}, 43'h0);
        rst_n = 1'b1;
        tick();

        run_dump(10'h000, 11'd4, 0, -1);
        verify_dump("basic", 10'h000, 4, 0);

        run_dump(10'h000, 11'd4, 0, 2);
        verify_dump("start_busy", 10'h000, 4, 0);
        tick();
        tick();
        check("start_busy_idle", {busy, mem_rd_en, out_valid}, 3'b000);

        run_dump(10'h000, 11'd4, 1, -1);
        verify_dump("bp_toggle", 10'h000, 4, 1);

        run_dump(10'h010, 11'd8, 2, -1);
        verify_dump("bp_stall", 10'h010, 8, 2);
        check("bp_stall_max_out", max_out, 4);

        run_dump(10'h3FE, 11'd4, 0, -1);
        verify_dump("wrap", 10'h3FE, 4, 0);

        run_dump(10'h000, 11'd0, 0, -1);
        verify_dump("zero", 10'h000, 0, 0);

        base_addr = 10'h010; word_count = 11'd8; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_valid_c5", out_valid, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid_c6", out_valid, 1'b0);
        check("abort_busy_c6", busy, 1'b0);
        check("abort_done_c6", done, 1'b0);
        check("abort_rd_en_c6", mem_rd_en, 1'b0);
        tick();
        check("abort_done_c7", done, 1'b0);
        run_dump(10'h020, 11'd2, 0, -1);
        verify_dump("after_abort", 10'h020, 2, 0);

        base_addr = 10'h000; word_count = 11'd4; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("mid_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs",
              {busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, out_last},
              57'h0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", {busy, done, out_valid, mem_rd_en}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
